ex_cond_stage: RTL

Execute-stage back end that sits directly downstream of the ALU. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit ARM condition field against it. It updates the flags from the ALU's flag output under FlagW control, gates the write/branch controls, and registers the result into an EX→MEM pipeline register with a valid/ready handshake and flush. It also keeps a saturating count of condition-failed instructions for debug.

---
 rtl/ex_pkg.sv | 58 +++++
 rtl/ex_cond_stage_cond_check.sv | 45 ++++
 rtl/ex_cond_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: ARM condition codes, NZCV flag layout
// and the flag-merge helper used when the ALU writes a subset of the flags.
package ex_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RA_W_DEF   = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned COND_W     = 4;
    localparam int unsigned FLAGW_W    = 2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Merge ALU flags into the architectural flags under the FlagW byte-enables.
    function automatic logic [FLAGS_W-1:0] merge_flags(
        input logic [FLAGS_W-1:0] old_flags,
        input logic [FLAGS_W-1:0] alu_flags,
        input logic [FLAGW_W-1:0] flag_w
    );
        logic [FLAGS_W-1:0] merged;
        merged = old_flags;
        if (flag_w[FLAGW_NZ]) begin
            merged[FLAG_N] = alu_flags[FLAG_N];
            merged[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_w[FLAGW_CV]) begin
            merged[FLAG_C] = alu_flags[FLAG_C];
            merged[FLAG_V] = alu_flags[FLAG_V];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational ARM condition evaluator; shared with the branch-predictor check.
module cond_check
    import ex_pkg::*;
(
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b1;
        case (cond_e'(Cond))
            EQ: CondEx = w_z;
            NE: CondEx = ~w_z;
            CS: CondEx = w_c;
            CC: CondEx = ~w_c;
            MI: CondEx = w_n;
            PL: CondEx = ~w_n;
            VS: CondEx = w_v;
            VC: CondEx = ~w_v;
            HI: CondEx = w_c & ~w_z;
            LS: CondEx = ~w_c | w_z;
            GE: CondEx = w_ge;
            LT: CondEx = ~w_ge;
            GT: CondEx = ~w_z & w_ge;
            LE: CondEx = w_z | ~w_ge;
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_cond_stage.sv
// Execute-stage back end: NZCV flag register, condition gating of write/branch
// controls, EX->MEM pipeline register with valid/ready/flush, cond-fail counter.
module ex_cond_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COND_W-1:0]   Cond,
    input  logic [FLAGW_W-1:0]  FlagW,
    input  logic [DATA_W-1:0]   ALUResult,
    input  logic [FLAGS_W-1:0]  ALUFlag,
    input  logic [RA_W-1:0]     WA3,
    input  logic                RegW,
    input  logic                MemW,
    input  logic                PCS,
    input  logic                NoWrite,
    input  logic                flush,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_result,
    output logic [RA_W-1:0]     out_wa3,
    output logic                out_regwrite,
    output logic                out_memwrite,
    output logic                out_pcsrc,
    output logic [FLAGS_W-1:0]  Flags,
    output logic [CNT_W-1:0]    cond_fail_cnt
);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_result;
    logic [RA_W-1:0]     r_out_wa3;
    logic                r_out_regwrite;
    logic                r_out_memwrite;
    logic                r_out_pcsrc;
    logic [FLAGS_W-1:0]  r_flags;
    logic [CNT_W-1:0]    r_cond_fail_cnt;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_cond_ex;

    // Condition is evaluated against the registered flags, so a flag-setting
    // instruction is visible to the very next accepted instruction.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_cond_ex)
    );

    assign w_in_ready = ~flush & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & w_in_ready;

    // Pipeline valid: flush squashes the held instruction even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (flush || out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Payload and gated controls only move on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result   <= '0;
            r_out_wa3      <= '0;
            r_out_regwrite <= 1'b0;
            r_out_memwrite <= 1'b0;
            r_out_pcsrc    <= 1'b0;
        end else if (w_accept) begin
            r_out_result   <= ALUResult;
            r_out_wa3      <= WA3;
            r_out_regwrite <= RegW & w_cond_ex & ~NoWrite;
            r_out_memwrite <= MemW & w_cond_ex;
            r_out_pcsrc    <= PCS & w_cond_ex;
        end
    end

    // Architectural flags: only a condition-passing accepted instruction writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_accept && w_cond_ex) begin
            r_flags <= merge_flags(r_flags, ALUFlag, FlagW);
        end
    end

    // Saturating count of accepted instructions that failed their condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond_fail_cnt <= '0;
        end else if (w_accept && !w_cond_ex && (r_cond_fail_cnt != '1)) begin
            r_cond_fail_cnt <= r_cond_fail_cnt + CNT_W'(1);
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_wa3       = r_out_wa3;
    assign out_regwrite  = r_out_regwrite;
    assign out_memwrite  = r_out_memwrite;
    assign out_pcsrc     = r_out_pcsrc;
    assign Flags         = r_flags;
    assign cond_fail_cnt = r_cond_fail_cnt;

endmodule
